// File: rtl/counter_4bit_down_timer_if.sv
// ---------------------------------------------------------------------------
// counter_4bit_down_timer_if
//   Control/status bundle between the controller (master) and the down timer
//   (slave).
//
//   Ports carried:
//     load_val    master->slave  WIDTH  interval, sampled on an accepted start
//     start       master->slave  1      load load_val and begin counting
//     pause       master->slave  1      hold the count while high
//     abort       master->slave  1      cancel the running count
//     auto_reload master->slave  1      periodic mode, sampled on start
//     q           slave->master  WIDTH  current count (registered)
//     busy        slave->master  1      counting or paused
//     paused      slave->master  1      paused
//     done        slave->master  1      one-cycle expiry pulse (registered)
//     is_all_zero slave->master  1      q == 0 (combinational)
// ---------------------------------------------------------------------------
interface counter_4bit_down_timer_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] load_val;
  logic             start;
  logic             pause;
  logic             abort;
  logic             auto_reload;
  logic [WIDTH-1:0] q;
  logic             busy;
  logic             paused;
  logic             done;
  logic             is_all_zero;

  modport master (
    output load_val, start, pause, abort, auto_reload,
    input  q, busy, paused, done, is_all_zero
  );

  modport slave (
    input  load_val, start, pause, abort, auto_reload,
    output q, busy, paused, done, is_all_zero
  );
endinterface

// File: rtl/counter_4bit_down_timer.sv
// ---------------------------------------------------------------------------
// counter_4bit_down_timer
//   Loadable synchronous down counter with start/done handshake, one-shot or
//   auto-reload operation, pause and abort. Used by the controller as the
//   timing element for wait states.
//
//   Ports:
//     clk    input   system clock, all state changes on the rising edge
//     clr_n  input   synchronous reset, active-low
//     bus    slave   control/status bundle (see counter_4bit_down_timer_if)
//
//   Edge priority: clr_n, abort, start (IDLE only), pause, decrement.
//   WIDTH must match the WIDTH of the connected interface instance.
// ---------------------------------------------------------------------------
module counter_4bit_down_timer #(
  parameter int WIDTH = 4
) (
  input  logic                        clk,
  input  logic                        clr_n,
  counter_4bit_down_timer_if.slave    bus
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_RUN    = 2'd1;
  localparam logic [1:0] ST_PAUSED = 2'd2;

  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
  localparam logic [WIDTH-1:0] ZERO = '0;

  logic [1:0]       state;
  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] reload_reg;
  logic             mode_reg;
  logic             done_r;

  // NOTE: all state uses non-blocking assignments so every register sees the
  // pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      state      <= ST_IDLE;
      q_r        <= ZERO;
      reload_reg <= ZERO;
      mode_reg   <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      // done is a pulse: cleared every edge unless an expiry below sets it.
      done_r <= 1'b0;

      if (bus.abort && (state != ST_IDLE)) begin
        // Cancelling is silent: no done pulse.
        q_r   <= ZERO;
        state <= ST_IDLE;
      end else begin
        case (state)
          ST_IDLE: begin
            if (bus.start) begin
              if (bus.load_val != ZERO) begin
                q_r        <= bus.load_val;
                reload_reg <= bus.load_val;
                mode_reg   <= bus.auto_reload;
                state      <= ST_RUN;
              end else begin
                // A zero interval expires immediately without leaving IDLE.
                done_r <= 1'b1;
              end
            end
          end

          ST_RUN: begin
            if (bus.pause) begin
              state <= ST_PAUSED;
            end else if (q_r > ONE) begin
              q_r <= q_r - ONE;
            end else if (q_r == ONE) begin
              done_r <= 1'b1;
              if (mode_reg) begin
                // Periodic mode reloads instead of showing 0.
                q_r <= reload_reg;
              end else begin
                q_r   <= ZERO;
                state <= ST_IDLE;
              end
            end else begin
              // q == 0 cannot occur in RUN; recover to IDLE rather than wrap.
              state <= ST_IDLE;
            end
          end

          ST_PAUSED: begin
            // The resume edge only changes state; decrement starts next edge.
            if (!bus.pause) begin
              state <= ST_RUN;
            end
          end

          default: begin
            state <= ST_IDLE;
            q_r   <= ZERO;
          end
        endcase
      end
    end
  end

  assign bus.q           = q_r;
  assign bus.done        = done_r;
  assign bus.busy        = (state == ST_RUN) || (state == ST_PAUSED);
  assign bus.paused      = (state == ST_PAUSED);
  assign bus.is_all_zero = (q_r == ZERO);

endmodule

// File: tb/tb_counter_4bit_down_timer.sv
// ---------------------------------------------------------------------------
// tb_counter_4bit_down_timer
//   Directed bench for the down timer: a 4-bit and an 8-bit instance share
//   clk and clr_n. Stimulus is applied on the falling edge together with the
//   expected post-edge outputs, which go into a scoreboard queue; a monitor
//   pops one entry after each rising edge and compares it with the DUT it
//   names.
// ---------------------------------------------------------------------------
module tb_counter_4bit_down_timer;

  typedef struct {
    string      name;
    bit         sel8;
    logic [7:0] q;
    logic       busy;
    logic       paused;
    logic       done;
  } exp_t;

  logic clk;
  logic clr_n;
  int   checks;
  int   errors;
  exp_t sb_q[$];

  counter_4bit_down_timer_if #(.WIDTH(4)) b4 ();
  counter_4bit_down_timer_if #(.WIDTH(8)) b8 ();

  counter_4bit_down_timer #(.WIDTH(4)) dut4 (
    .clk   (clk),
    .clr_n (clr_n),
    .bus   (b4.slave)
  );

  counter_4bit_down_timer #(.WIDTH(8)) dut8 (
    .clk   (clk),
    .clr_n (clr_n),
    .bus   (b8.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One stimulus cycle on the 4-bit instance plus its expected outputs.
  task automatic step4(input string nm, input logic c, input logic st,
                       input logic [3:0] lv, input logic pa, input logic ab,
                       input logic ar, input logic [3:0] eq, input logic eb,
                       input logic ep, input logic ed);
    exp_t e;
    @(negedge clk);
    clr_n          = c;
    b4.start       = st;
    b4.load_val    = lv;
    b4.pause       = pa;
    b4.abort       = ab;
    b4.auto_reload = ar;
    b8.start       = 1'b0;
    e.name   = nm;
    e.sel8   = 1'b0;
    e.q      = {4'h0, eq};
    e.busy   = eb;
    e.paused = ep;
    e.done   = ed;
    sb_q.push_back(e);
  endtask

  // One stimulus cycle on the 8-bit instance (one-shot, no pause/abort).
  task automatic step8(input string nm, input logic st, input logic [7:0] lv,
                       input logic [7:0] eq, input logic eb, input logic ed);
    exp_t e;
    @(negedge clk);
    clr_n          = 1'b1;
    b4.start       = 1'b0;
    b8.start       = st;
    b8.load_val    = lv;
    b8.pause       = 1'b0;
    b8.abort       = 1'b0;
    b8.auto_reload = 1'b0;
    e.name   = nm;
    e.sel8   = 1'b1;
    e.q      = eq;
    e.busy   = eb;
    e.paused = 1'b0;
    e.done   = ed;
    sb_q.push_back(e);
  endtask

  // Monitor: compare one scoreboard entry after every rising edge.
  initial begin
    exp_t       e;
    logic [7:0] gq;
    logic       gb, gp, gd, gz;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        if (e.sel8) begin
          gq = b8.q;
          gb = b8.busy; gp = b8.paused; gd = b8.done; gz = b8.is_all_zero;
        end else begin
          gq = {4'h0, b4.q};
          gb = b4.busy; gp = b4.paused; gd = b4.done; gz = b4.is_all_zero;
        end
        checks++;
        if (gq !== e.q || gb !== e.busy || gp !== e.paused ||
            gd !== e.done || gz !== (e.q == 8'd0)) begin
          errors++;
          $display("FAIL %s: got q=%0d busy=%b paused=%b done=%b zero=%b, expected q=%0d busy=%b paused=%b done=%b zero=%b",
                   e.name, gq, gb, gp, gd, gz,
                   e.q, e.busy, e.paused, e.done, (e.q == 8'd0));
        end
      end
    end
  end

  // Global time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, %0d entries pending", sb_q.size());
    $fatal(1, "timeout");
  end

  initial begin
    checks = 0;
    errors = 0;
    clr_n = 1'b0;
    b4.start = 1'b0; b4.load_val = '0; b4.pause = 1'b0; b4.abort = 1'b0; b4.auto_reload = 1'b0;
    b8.start = 1'b0; b8.load_val = '0; b8.pause = 1'b0; b8.abort = 1'b0; b8.auto_reload = 1'b0;

    // Reset held for two edges while start is asserted.
    step4("reset0", 0, 1, 4'd7, 0, 0, 0, 4'd0, 0, 0, 0);
    step4("reset1", 0, 1, 4'd7, 0, 0, 0, 4'd0, 0, 0, 0);

    // One-shot 5: start accepted on the first edge after release.
    step4("os_load", 1, 1, 4'd5, 0, 0, 0, 4'd5, 1, 0, 0);
    step4("os_4",    1, 0, 4'd0, 0, 0, 0, 4'd4, 1, 0, 0);
    step4("os_3",    1, 0, 4'd0, 0, 0, 0, 4'd3, 1, 0, 0);
    step4("os_2",    1, 0, 4'd0, 0, 0, 0, 4'd2, 1, 0, 0);
    step4("os_1",    1, 0, 4'd0, 0, 0, 0, 4'd1, 1, 0, 0);
    step4("os_0",    1, 0, 4'd0, 0, 0, 0, 4'd0, 0, 0, 1);
    step4("os_idle", 1, 0, 4'd0, 0, 0, 0, 4'd0, 0, 0, 0);

    // Auto-reload 3: 3,2,1,3,2,1,3,2,1,3 with done on each reload.
    step4("ar_load", 1, 1, 4'd3, 0, 0, 1, 4'd3, 1, 0, 0);
    for (int r = 0; r < 3; r++) begin
      step4("ar_2",   1, 0, 4'd0, 0, 0, 0, 4'd2, 1, 0, 0);
      step4("ar_1",   1, 0, 4'd0, 0, 0, 0, 4'd1, 1, 0, 0);
      step4("ar_rld", 1, 0, 4'd0, 0, 0, 0, 4'd3, 1, 0, 1);
    end
    step4("ar_abort", 1, 0, 4'd0, 0, 1, 0, 4'd0, 0, 0, 0);

    // Pause at q=4 for three edges; resume edge holds 4.
    step4("pz_load",   1, 1, 4'd6, 0, 0, 0, 4'd6, 1, 0, 0);
    step4("pz_5",      1, 0, 4'd0, 0, 0, 0, 4'd5, 1, 0, 0);
    step4("pz_4",      1, 0, 4'd0, 0, 0, 0, 4'd4, 1, 0, 0);
    step4("pz_hold1",  1, 0, 4'd0, 1, 0, 0, 4'd4, 1, 1, 0);
    step4("pz_hold2",  1, 1, 4'd9, 1, 0, 0, 4'd4, 1, 1, 0);
    step4("pz_hold3",  1, 0, 4'd0, 1, 0, 0, 4'd4, 1, 1, 0);
    step4("pz_resume", 1, 0, 4'd0, 0, 0, 0, 4'd4, 1, 0, 0);
    step4("pz_3",      1, 0, 4'd0, 0, 0, 0, 4'd3, 1, 0, 0);
    step4("pz_2",      1, 0, 4'd0, 0, 0, 0, 4'd2, 1, 0, 0);
    step4("pz_1",      1, 0, 4'd0, 0, 0, 0, 4'd1, 1, 0, 0);
    step4("pz_0",      1, 0, 4'd0, 0, 0, 0, 4'd0, 0, 0, 1);

    // Abort at q=2: silent return to IDLE.
    step4("ab_load",  1, 1, 4'd6, 0, 0, 0, 4'd6, 1, 0, 0);
    step4("ab_5",     1, 0, 4'd0, 0, 0, 0, 4'd5, 1, 0, 0);
    step4("ab_4",     1, 0, 4'd0, 0, 0, 0, 4'd4, 1, 0, 0);
    step4("ab_3",     1, 0, 4'd0, 0, 0, 0, 4'd3, 1, 0, 0);
    step4("ab_2",     1, 0, 4'd0, 0, 0, 0, 4'd2, 1, 0, 0);
    step4("ab_abort", 1, 0, 4'd0, 0, 1, 0, 4'd0, 0, 0, 0);
    step4("ab_idle",  1, 0, 4'd0, 0, 0, 0, 4'd0, 0, 0, 0);

    // Zero interval: immediate done, never busy.
    step4("z_start", 1, 1, 4'd0, 0, 0, 0, 4'd0, 0, 0, 1);
    step4("z_idle",  1, 0, 4'd0, 0, 0, 0, 4'd0, 0, 0, 0);

    // Restart while busy is ignored (auto_reload change ignored too).
    step4("rs_load",   1, 1, 4'd5, 0, 0, 0, 4'd5, 1, 0, 0);
    step4("rs_4",      1, 0, 4'd0, 0, 0, 0, 4'd4, 1, 0, 0);
    step4("rs_3",      1, 0, 4'd0, 0, 0, 0, 4'd3, 1, 0, 0);
    step4("rs_ignore", 1, 1, 4'd9, 0, 0, 1, 4'd2, 1, 0, 0);
    step4("rs_1",      1, 0, 4'd0, 0, 0, 1, 4'd1, 1, 0, 0);
    step4("rs_0",      1, 0, 4'd0, 0, 0, 0, 4'd0, 0, 0, 1);

    // Reset mid-count at q=2: no done pulse.
    step4("cl_load",  1, 1, 4'd4, 0, 0, 0, 4'd4, 1, 0, 0);
    step4("cl_3",     1, 0, 4'd0, 0, 0, 0, 4'd3, 1, 0, 0);
    step4("cl_2",     1, 0, 4'd0, 0, 0, 0, 4'd2, 1, 0, 0);
    step4("cl_clear", 0, 0, 4'd0, 0, 0, 0, 4'd0, 0, 0, 0);
    step4("cl_idle",  1, 0, 4'd0, 0, 0, 0, 4'd0, 0, 0, 0);

    // 8-bit instance: load 200, done exactly 200 edges after the load edge.
    step8("w8_load", 1, 8'd200, 8'd200, 1, 0);
    for (int i = 1; i < 200; i++) begin
      step8("w8_count", 0, 8'd0, 8'(200 - i), 1, 0);
    end
    step8("w8_done", 0, 8'd0, 8'd0, 0, 1);
    step8("w8_idle", 0, 8'd0, 8'd0, 0, 0);

    // Drain the scoreboard with a bounded wait.
    for (int k = 0; k < 10 && sb_q.size() > 0; k++) begin
      @(posedge clk);
    end
    @(posedge clk);
    #2;
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending entries, expected 0", sb_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
